// File: rtl/mem_arbiter_2to1.sv
// mem_arbiter_2to1
//   Merges an instruction client (imem_*) and a data client (dmem_*) onto a single
//   memory put/get port pair. Requests are arbitrated round-robin and pass through
//   combinationally. An in-order tag FIFO remembers which client issued each request,
//   so every memory response is steered back to the owner of the oldest outstanding
//   request.
//
// Parameters
//   REQ_WIDTH  payload width {byte_en[3:0], addr[31:0], data[31:0]}, passed unmodified
//   TAG_DEPTH  maximum outstanding requests (power of 2, >= 2)
//
// Ports
//   CLK, RST_N                        clock, synchronous active-low reset
//   imem_req_valid/ready/req          imem request handshake and payload
//   imem_resp_valid/ready/resp        imem response handshake and payload
//   dmem_*                            same six ports for the data client
//   mem_put_valid/ready/request       request handshake towards memory
//   mem_get_ready/valid/response      response handshake from memory
//                                     (mem_get_ready = memory has a response,
//                                      mem_get_valid = arbiter dequeues it)
//   err_orphan                        sticky: response offered with nothing outstanding
//   perf_imem_grants/perf_dmem_grants put-transfer counters per client
//
// Configuration
//   ARB_PERF_COUNTERS_EN  when defined, the perf outputs count put transfers per client
//                         (32-bit, wrapping); when undefined they are tied to 0.

module mem_arbiter_2to1 #(
    parameter int unsigned REQ_WIDTH = 68,
    parameter int unsigned TAG_DEPTH = 4
) (
    input  logic                 CLK,
    input  logic                 RST_N,

    input  logic                 imem_req_valid,
    output logic                 imem_req_ready,
    input  logic [REQ_WIDTH-1:0] imem_req,
    output logic                 imem_resp_valid,
    input  logic                 imem_resp_ready,
    output logic [REQ_WIDTH-1:0] imem_resp,

    input  logic                 dmem_req_valid,
    output logic                 dmem_req_ready,
    input  logic [REQ_WIDTH-1:0] dmem_req,
    output logic                 dmem_resp_valid,
    input  logic                 dmem_resp_ready,
    output logic [REQ_WIDTH-1:0] dmem_resp,

    output logic                 mem_put_valid,
    input  logic                 mem_put_ready,
    output logic [REQ_WIDTH-1:0] mem_put_request,
    input  logic                 mem_get_ready,
    output logic                 mem_get_valid,
    input  logic [REQ_WIDTH-1:0] mem_get_response,

    output logic                 err_orphan,
    output logic [31:0]          perf_imem_grants,
    output logic [31:0]          perf_dmem_grants
);

    localparam int unsigned PtrW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(TAG_DEPTH + 1);

    typedef logic [PtrW-1:0] ptr_t;
    typedef logic [CntW-1:0] cnt_t;

    // Tag FIFO: one bit per entry, 0 = imem, 1 = dmem.
    logic [TAG_DEPTH-1:0] tag_q;
    ptr_t                 wr_ptr_q;
    ptr_t                 rd_ptr_q;
    cnt_t                 count_q;
    logic                 rr_q;
    logic                 err_orphan_q;

    logic full;
    logic empty;
    logic head_id;
    logic winner_exists;
    logic winner_id;
    logic push;
    logic pop;

    assign full    = (count_q == cnt_t'(TAG_DEPTH));
    assign empty   = (count_q == '0);
    assign head_id = tag_q[rd_ptr_q];

    always_comb begin
        winner_exists = imem_req_valid | dmem_req_valid;
        // Lone requester wins; on contention the rr pointer decides.
        winner_id     = (imem_req_valid & dmem_req_valid) ? rr_q : dmem_req_valid;

        mem_put_valid   = RST_N & winner_exists & ~full;
        mem_put_request = winner_id ? dmem_req : imem_req;
        imem_req_ready  = RST_N & winner_exists & ~winner_id & mem_put_ready & ~full;
        dmem_req_ready  = RST_N & winner_exists & winner_id & mem_put_ready & ~full;

        imem_resp_valid = RST_N & mem_get_ready & ~empty & ~head_id;
        dmem_resp_valid = RST_N & mem_get_ready & ~empty & head_id;
        mem_get_valid   = RST_N & ~empty & (head_id ? dmem_resp_ready : imem_resp_ready);

        push = mem_put_valid & mem_put_ready;
        pop  = mem_get_valid & mem_get_ready;
    end

    assign imem_resp  = mem_get_response;
    assign dmem_resp  = mem_get_response;
    assign err_orphan = err_orphan_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            tag_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rr_q         <= 1'b0;
            err_orphan_q <= 1'b0;
        end else begin
            if (push) begin
                tag_q[wr_ptr_q] <= winner_id;
                wr_ptr_q        <= wr_ptr_q + ptr_t'(1);
                rr_q            <= ~winner_id;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + ptr_t'(1);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + cnt_t'(1);
                2'b01:   count_q <= count_q - cnt_t'(1);
                default: count_q <= count_q;
            endcase
            if (mem_get_ready && empty) begin
                err_orphan_q <= 1'b1;
            end
        end
    end

`ifdef ARB_PERF_COUNTERS_EN
    logic [31:0] perf_imem_q;
    logic [31:0] perf_dmem_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            perf_imem_q <= '0;
            perf_dmem_q <= '0;
        end else if (push) begin
            if (winner_id) begin
                perf_dmem_q <= perf_dmem_q + 32'd1;
            end else begin
                perf_imem_q <= perf_imem_q + 32'd1;
            end
        end
    end

    assign perf_imem_grants = perf_imem_q;
    assign perf_dmem_grants = perf_dmem_q;
`else
    assign perf_imem_grants = '0;
    assign perf_dmem_grants = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter_2to1.sv
// Directed self-checking bench for mem_arbiter_2to1 (REQ_WIDTH=68, TAG_DEPTH=4).
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.

module tb_mem_arbiter_2to1;

    localparam int unsigned W = 68;

    localparam logic [W-1:0] IREQ = {4'hF, 32'h0000_1000, 32'hA5A5_0001};
    localparam logic [W-1:0] DREQ = {4'h3, 32'h0000_2000, 32'h5A5A_0002};
    localparam logic [W-1:0] T4I  = {4'hF, 32'h0000_0100, 32'hDEAD_0001};
    localparam logic [W-1:0] T4D  = {4'h3, 32'h0000_0200, 32'hBEEF_0002};
    localparam logic [W-1:0] R1   = {4'hF, 32'h0000_0100, 32'h1234_5678};
    localparam logic [W-1:0] R2   = {4'h3, 32'h0000_0200, 32'h8765_4321};

    logic         CLK = 1'b0;
    logic         RST_N;
    logic         imem_req_valid, imem_req_ready, imem_resp_valid, imem_resp_ready;
    logic         dmem_req_valid, dmem_req_ready, dmem_resp_valid, dmem_resp_ready;
    logic [W-1:0] imem_req, imem_resp, dmem_req, dmem_resp;
    logic         mem_put_valid, mem_put_ready, mem_get_ready, mem_get_valid;
    logic [W-1:0] mem_put_request, mem_get_response;
    logic         err_orphan;
    logic [31:0]  perf_imem_grants, perf_dmem_grants;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    mem_arbiter_2to1 #(
        .REQ_WIDTH(W),
        .TAG_DEPTH(4)
    ) dut (
        .CLK              (CLK),
        .RST_N            (RST_N),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_req         (imem_req),
        .imem_resp_valid  (imem_resp_valid),
        .imem_resp_ready  (imem_resp_ready),
        .imem_resp        (imem_resp),
        .dmem_req_valid   (dmem_req_valid),
        .dmem_req_ready   (dmem_req_ready),
        .dmem_req         (dmem_req),
        .dmem_resp_valid  (dmem_resp_valid),
        .dmem_resp_ready  (dmem_resp_ready),
        .dmem_resp        (dmem_resp),
        .mem_put_valid    (mem_put_valid),
        .mem_put_ready    (mem_put_ready),
        .mem_put_request  (mem_put_request),
        .mem_get_ready    (mem_get_ready),
        .mem_get_valid    (mem_get_valid),
        .mem_get_response (mem_get_response),
        .err_orphan       (err_orphan),
        .perf_imem_grants (perf_imem_grants),
        .perf_dmem_grants (perf_dmem_grants)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Reset with every input asserted.
        RST_N            = 1'b0;
        imem_req_valid   = 1'b1;
        dmem_req_valid   = 1'b1;
        imem_resp_ready  = 1'b1;
        dmem_resp_ready  = 1'b1;
        mem_put_ready    = 1'b1;
        mem_get_ready    = 1'b1;
        imem_req         = IREQ;
        dmem_req         = DREQ;
        mem_get_response = R1;
        for (int k = 0; k < 2; k++) begin
            cyc();
            #1;
            check("rst_outs", {imem_req_ready, dmem_req_ready, mem_put_valid, imem_resp_valid,
                               dmem_resp_valid, mem_get_valid, err_orphan}, 7'b0);
            check("rst_perf", {perf_imem_grants, perf_dmem_grants}, 64'd0);
        end
        cyc();
        RST_N          = 1'b1;
        imem_req_valid = 1'b0;
        dmem_req_valid = 1'b0;
        mem_get_ready  = 1'b0;

        // Both clients always valid: grants alternate starting with imem, drained each cycle.
        imem_req_valid = 1'b1;
        dmem_req_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k == 1) mem_get_ready = 1'b1;
            #1;
            check("t2_i_rdy", imem_req_ready, (k % 2) == 0);
            check("t2_d_rdy", dmem_req_ready, (k % 2) == 1);
            check("t2_put_req", mem_put_request, (k % 2 == 0) ? IREQ : DREQ);
            if (k >= 1) begin
                check("t2_i_rsp_vld", imem_resp_valid, ((k - 1) % 2) == 0);
                check("t2_get_vld", mem_get_valid, 1'b1);
            end
            cyc();
        end
        imem_req_valid = 1'b0;
        dmem_req_valid = 1'b0;
        #1;
        check("t2_last_d_rsp", {dmem_resp_valid, imem_resp_valid, mem_get_valid}, 3'b101);
        check("t2_put_idle", mem_put_valid, 1'b0);
        cyc();
        mem_get_ready = 1'b0;
        #1;
        check("t2_no_orphan", err_orphan, 1'b0);
`ifdef ARB_PERF_COUNTERS_EN
        check("perf_imem", perf_imem_grants, 32'd5);
        check("perf_dmem", perf_dmem_grants, 32'd5);
`else
        check("perf_imem", perf_imem_grants, 32'd0);
        check("perf_dmem", perf_dmem_grants, 32'd0);
`endif
        cyc();

        // Only imem, no responses: four grants fill the FIFO, then ready stalls.
        imem_req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t3_fill_rdy", {imem_req_ready, mem_put_valid}, 2'b11);
            cyc();
        end
        for (int k = 0; k < 2; k++) begin
            #1;
            check("t3_full_rdy", {imem_req_ready, mem_put_valid}, 2'b00);
            cyc();
        end
        // Pop while full: push stays blocked in the same cycle.
        mem_get_ready = 1'b1;
        #1;
        check("t3_pop_get", mem_get_valid, 1'b1);
        check("t3_pop_rdy", imem_req_ready, 1'b0);
        cyc();
        mem_get_ready = 1'b0;
        #1;
        check("t3_5th_grant", {imem_req_ready, mem_put_valid}, 2'b11);
        cyc();
        imem_req_valid = 1'b0;
        mem_get_ready  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mem_get_response = {4'h1, 32'h0000_0040, 32'(k) + 32'hC0DE_0000};
            #1;
            check("t3_drain_vld", {imem_resp_valid, dmem_resp_valid}, 2'b10);
            check("t3_drain_data", imem_resp, {4'h1, 32'h0000_0040, 32'(k) + 32'hC0DE_0000});
            cyc();
        end
        mem_get_ready = 1'b0;
        #1;
        check("t3_empty", {mem_get_valid, err_orphan}, 2'b00);
        cyc();

        // In-order return across clients with bit-exact payloads.
        imem_req_valid = 1'b1;
        imem_req       = T4I;
        #1;
        check("t4_put_i", mem_put_request, T4I);
        check("t4_i_rdy", imem_req_ready, 1'b1);
        cyc();
        imem_req_valid = 1'b0;
        dmem_req_valid = 1'b1;
        dmem_req       = T4D;
        #1;
        check("t4_put_d", mem_put_request, T4D);
        check("t4_d_rdy", dmem_req_ready, 1'b1);
        cyc();
        dmem_req_valid   = 1'b0;
        mem_get_ready    = 1'b1;
        mem_get_response = R1;
        #1;
        check("t4_rsp1_vld", {imem_resp_valid, dmem_resp_valid}, 2'b10);
        check("t4_rsp1_data", imem_resp, R1);
        cyc();
        mem_get_response = R2;
        #1;
        check("t4_rsp2_vld", {imem_resp_valid, dmem_resp_valid}, 2'b01);
        check("t4_rsp2_data", dmem_resp, R2);
        cyc();
        mem_get_ready = 1'b0;

        // dmem at head stalls its response for three cycles.
        dmem_req_valid = 1'b1;
        #1;
        check("t5_grant", dmem_req_ready, 1'b1);
        cyc();
        dmem_req_valid  = 1'b0;
        mem_get_ready   = 1'b1;
        dmem_resp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t5_stall", {mem_get_valid, imem_resp_valid, dmem_resp_valid}, 3'b001);
            cyc();
        end
        dmem_resp_ready = 1'b1;
        #1;
        check("t5_pop", mem_get_valid, 1'b1);
        cyc();
        mem_get_ready = 1'b0;
        #1;
        check("t5_after", {mem_get_valid, err_orphan}, 2'b00);
        cyc();

        // Orphan response: flag rises next cycle and sticks until reset.
        mem_get_ready = 1'b1;
        #1;
        check("t6_orphan_cyc", {mem_get_valid, imem_resp_valid, dmem_resp_valid, err_orphan},
              4'b0000);
        cyc();
        mem_get_ready = 1'b0;
        #1;
        check("t6_orphan_set", err_orphan, 1'b1);
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("t6_orphan_hold", err_orphan, 1'b1);
        end
        RST_N = 1'b0;
        cyc();
        RST_N = 1'b1;
        #1;
        check("t6_orphan_clr", err_orphan, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
